// File: rtl/digit_scan_controller.sv
// BCD up-counter with a time-multiplexed, active-low common-anode 7-segment scanner.
// Each slot is SCAN_DIV cycles: BLANK cycles with all anodes off, then the digit is driven.
module digit_scan_controller #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK    = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ativador,
    input  logic                  step,
    input  logic                  clear,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   value,
    output logic                  overflow
);

    localparam int TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [TW-1:0] T_BLANK_END = TW'(BLANK - 1);
    localparam logic [TW-1:0] T_SLOT_END  = TW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] S_LAST      = SW'(DIGITS - 1);

    typedef enum logic {S_BLANK = 1'b0, S_DRIVE = 1'b1} state_t;

    state_t                state;
    logic [TW-1:0]         timer;
    logic [SW-1:0]         slot;
    logic [4*DIGITS-1:0]   value_next;
    logic                  all_nines;
    logic                  carry;
    logic [DIGITS-1:0]     suppress;
    logic                  zero_above;
    logic [3:0]            digit_sel;
    logic                  suppress_sel;
    logic [6:0]            seg_sel;
    logic [DIGITS-1:0]     an_sel;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0000001;
            4'd1:    decode = 7'b1001111;
            4'd2:    decode = 7'b0010010;
            4'd3:    decode = 7'b0000110;
            4'd4:    decode = 7'b1001100;
            4'd5:    decode = 7'b0100100;
            4'd6:    decode = 7'b0100000;
            4'd7:    decode = 7'b0001111;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0000100;
            default: decode = 7'b1111111;
        endcase
    endfunction

    // Ripple increment: carry survives the loop only if every digit was 9.
    always_comb begin
        value_next = value;
        carry      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value[4*i +: 4] == 4'd9) begin
                    value_next[4*i +: 4] = 4'd0;
                end else begin
                    value_next[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry                = 1'b0;
                end
            end
        end
        all_nines = carry;
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        suppress   = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_above  = zero_above && (value[4*i +: 4] == 4'd0);
            suppress[i] = lz_blank && zero_above;
        end
    end

    always_comb begin
        digit_sel    = 4'd0;
        suppress_sel = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (SW'(i) == slot) begin
                digit_sel    = value[4*i +: 4];
                suppress_sel = suppress[i];
            end
        end
        seg_sel = suppress_sel ? 7'b1111111 : decode(digit_sel);
        an_sel  = ~(DIGITS'(1) << slot);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value    <= '0;
            overflow <= 1'b0;
            seg      <= 7'b1111111;
            an       <= '1;
            timer    <= '0;
            slot     <= '0;
            state    <= S_BLANK;
        end else begin
            overflow <= 1'b0;
            if (clear) begin
                value <= '0;
            end else if (step && ativador) begin
                value    <= value_next;
                overflow <= all_nines;
            end

            // Outputs are loaded with the state being entered, so an/seg track the FSM.
            case (state)
                S_BLANK: begin
                    timer <= timer + 1'b1;
                    if (timer == T_BLANK_END) begin
                        state <= S_DRIVE;
                        an    <= an_sel;
                        seg   <= seg_sel;
                    end else begin
                        an    <= '1;
                        seg   <= 7'b1111111;
                    end
                end
                S_DRIVE: begin
                    if (timer == T_SLOT_END) begin
                        timer <= '0;
                        slot  <= (slot == S_LAST) ? '0 : slot + 1'b1;
                        state <= S_BLANK;
                        an    <= '1;
                        seg   <= 7'b1111111;
                    end else begin
                        timer <= timer + 1'b1;
                        an    <= an_sel;
                        seg   <= seg_sel;
                    end
                end
                default: state <= S_BLANK;
            endcase
        end
    end

endmodule
